// File: rtl/soc_bram_ctl.sv
// Bus-side controller for four byte-wide synchronous BRAM lanes: 32-bit word
// requests with byte enables, one-cycle read latency sequencing, misalignment rejection.
module soc_bram_ctl #(
    parameter int addr_width = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_stb,
    input  logic                  i_rw,
    input  logic [31:0]           i_addr,
    input  logic [3:0]            i_be,
    input  logic [31:0]           i_dtw,
    output logic [31:0]           o_dtr,
    output logic                  o_ack,
    output logic                  o_err,
    output logic                  o_busy,
    output logic [addr_width-1:0] bram_addr,
    output logic [3:0]            bram_we,
    output logic [31:0]           bram_din,
    input  logic [31:0]           bram_dout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD1  = 2'd2,
        RD2  = 2'd3
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic                  ack_s;
    logic                  err_s;
    logic [31:0]           dtr_s;
    logic [addr_width-1:0] addr_s;
    logic [3:0]            we_s;
    logic [31:0]           din_s;
    logic [addr_width-1:0] widx_s;

    // Upper address bits are dropped so accesses alias modulo the mapped size
    assign widx_s = i_addr[addr_width+1:2];
    assign o_busy = (state_r != IDLE);

    // Next-state and next-output decode; ack/err/we fall back to 0 every cycle
    always_comb begin
        state_s = state_r;
        ack_s   = 1'b0;
        err_s   = 1'b0;
        dtr_s   = o_dtr;
        addr_s  = bram_addr;
        we_s    = 4'b0000;
        din_s   = bram_din;
        case (state_r)
            IDLE: begin
                if (i_stb) begin
                    if (i_addr[1:0] != 2'b00) begin
                        ack_s = 1'b1;
                        err_s = 1'b1;
                    end else if (i_rw) begin
                        addr_s  = widx_s;
                        din_s   = i_dtw;
                        we_s    = i_be;
                        state_s = WR;
                    end else begin
                        addr_s  = widx_s;
                        state_s = RD1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WR: begin
                ack_s   = 1'b1;
                state_s = IDLE;
            end
            RD1: begin
                // BRAM captures the addressed word on this edge
                state_s = RD2;
            end
            RD2: begin
                dtr_s   = bram_dout;
                ack_s   = 1'b1;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and registered BRAM/bus outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= IDLE;
            o_ack     <= 1'b0;
            o_err     <= 1'b0;
            o_dtr     <= 32'h0000_0000;
            bram_addr <= '0;
            bram_we   <= 4'b0000;
            bram_din  <= 32'h0000_0000;
        end else begin
            state_r   <= state_s;
            o_ack     <= ack_s;
            o_err     <= err_s;
            o_dtr     <= dtr_s;
            bram_addr <= addr_s;
            bram_we   <= we_s;
            bram_din  <= din_s;
        end
    end

endmodule

// File: tb/tb_soc_bram_ctl.sv
// Scoreboard bench for soc_bram_ctl: a lane-level BRAM model sits behind the DUT,
// and a word-level reference memory predicts every ack, its latency and data.
module tb_soc_bram_ctl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        i_stb = 1'b0;
    logic        i_rw = 1'b0;
    logic [31:0] i_addr = 32'h0;
    logic [3:0]  i_be = 4'h0;
    logic [31:0] i_dtw = 32'h0;
    logic [31:0] o_dtr;
    logic        o_ack;
    logic        o_err;
    logic        o_busy;
    logic [7:0]  bram_addr;
    logic [3:0]  bram_we;
    logic [31:0] bram_din;
    logic [31:0] bram_dout;

    soc_bram_ctl #(.addr_width(8)) dut (
        .clk(clk), .rstn(rstn), .i_stb(i_stb), .i_rw(i_rw), .i_addr(i_addr),
        .i_be(i_be), .i_dtw(i_dtw), .o_dtr(o_dtr), .o_ack(o_ack), .o_err(o_err),
        .o_busy(o_busy), .bram_addr(bram_addr), .bram_we(bram_we),
        .bram_din(bram_din), .bram_dout(bram_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Four byte lanes, read-first, one-cycle synchronous read
    bit [7:0] lane_mem [4][256];
    always @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            bram_dout[8*n +: 8] <= lane_mem[n][bram_addr];
            if (bram_we[n]) lane_mem[n][bram_addr] <= bram_din[8*n +: 8];
        end
    end

    typedef struct {
        bit          err;
        logic [31:0] dtr;
        logic [7:0]  idx;
        int          due;
    } exp_t;

    exp_t        q[$];
    bit   [31:0] ref_mem [256];
    logic [31:0] last_rd = 32'h0;
    logic [7:0]  last_idx = 8'h0;
    int          compared = 0;
    int          mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per ack and flags missing or spurious acks
    initial forever begin
        @(negedge clk);
        if (q.size() > 0 && cyc > q[0].due) begin
            compared++;
            mismatched++;
            $display("FAIL missing_ack: got none expected ack at cycle %0d", q[0].due);
            void'(q.pop_front());
        end
        if (rstn && o_ack) begin
            if (q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL spurious_ack: got ack expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("ack_err", {31'b0, o_err}, {31'b0, e.err});
                chk("ack_dtr", o_dtr, e.dtr);
                chk("ack_addr", {24'b0, bram_addr}, {24'b0, e.idx});
                chk("ack_latency", cyc, e.due);
            end
        end
    end

    // Predict the outcome from word-level rules, then drive one request
    task automatic issue(input bit rw, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] dtw);
        int   guard;
        int   idx;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (o_busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            compared++;
            mismatched++;
            $display("FAIL busy_timeout: got busy expected idle");
        end
        idx = int'((addr >> 2) % 32'd256);
        if (addr % 32'd4 != 32'd0) begin
            e = '{1'b1, last_rd, last_idx, cyc + 1};
        end else if (rw) begin
            for (int n = 0; n < 4; n++)
                if (be[n]) ref_mem[idx][8*n +: 8] = dtw[8*n +: 8];
            last_idx = 8'(idx);
            e = '{1'b0, last_rd, last_idx, cyc + 2};
        end else begin
            last_rd  = ref_mem[idx];
            last_idx = 8'(idx);
            e = '{1'b0, last_rd, last_idx, cyc + 3};
        end
        q.push_back(e);
        i_stb = 1'b1; i_rw = rw; i_addr = addr; i_be = be; i_dtw = dtw;
        @(posedge clk);
        #1;
        i_stb = 1'b0; i_rw = $urandom_range(0, 1); i_addr = $urandom;
        i_be = 4'($urandom); i_dtw = $urandom;
    endtask

    // One-cycle strobe while the controller is busy; must be ignored
    task automatic collide(input logic [31:0] addr);
        i_stb = 1'b1; i_rw = 1'b1; i_addr = addr; i_be = 4'hF; i_dtw = $urandom;
        @(posedge clk);
        #1;
        i_stb = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        bit          rw;
        repeat (3) @(negedge clk);
        chk("reset_ack", {31'b0, o_ack}, 32'd0);
        chk("reset_dtr", o_dtr, 32'h0);
        chk("reset_busy", {31'b0, o_busy}, 32'd0);
        rstn = 1'b1;

        // full word write/read
        issue(1'b1, 32'h0000_0010, 4'hF, 32'hDEADBEEF);
        issue(1'b0, 32'h0000_0010, 4'h0, 32'h0);
        // partial writes
        issue(1'b1, 32'h0000_0020, 4'hF, 32'h11223344);
        issue(1'b1, 32'h0000_0020, 4'b0101, 32'hAABBCCDD);
        issue(1'b0, 32'h0000_0020, 4'h0, 32'h0);
        issue(1'b1, 32'h0000_0020, 4'b0000, 32'hFFFFFFFF);
        issue(1'b0, 32'h0000_0020, 4'h0, 32'h0);
        // misaligned read: no BRAM write strobe
        issue(1'b0, 32'h0000_0012, 4'h0, 32'h0);
        @(negedge clk);
        chk("misaligned_we", {28'b0, bram_we}, 32'd0);
        // busy collision
        issue(1'b1, 32'h0000_0030, 4'hF, 32'h0BADF00D);
        issue(1'b0, 32'h0000_0010, 4'h0, 32'h0);
        collide(32'h0000_0030);
        issue(1'b0, 32'h0000_0030, 4'h0, 32'h0);
        // alias/wrap
        issue(1'b1, 32'h0000_0000, 4'hF, 32'hCAFE0001);
        issue(1'b1, 32'h0000_03FC, 4'hF, 32'h55667788);
        issue(1'b0, 32'h0000_0400, 4'h0, 32'h0);
        issue(1'b0, 32'h0000_03FC, 4'h0, 32'h0);
        issue(1'b1, 32'h0000_0400, 4'hF, 32'h12345678);
        issue(1'b0, 32'h0000_0000, 4'h0, 32'h0);

        // reset while in RD1
        issue(1'b0, 32'h0000_0010, 4'h0, 32'h0);
        #2 rstn = 1'b0;
        #1;
        chk("rst_ack", {31'b0, o_ack}, 32'd0);
        chk("rst_err", {31'b0, o_err}, 32'd0);
        chk("rst_dtr", o_dtr, 32'h0);
        chk("rst_we", {28'b0, bram_we}, 32'd0);
        chk("rst_addr", {24'b0, bram_addr}, 32'd0);
        chk("rst_busy", {31'b0, o_busy}, 32'd0);
        q.delete();
        last_rd = 32'h0;
        last_idx = 8'h0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        issue(1'b0, 32'h0000_0010, 4'h0, 32'h0);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[31:2] = 30'($urandom_range(0, 15));
            if ($urandom_range(0, 9) < 2) a[1:0] = 2'($urandom_range(1, 3));
            else a[1:0] = 2'b00;
            rw = 1'($urandom_range(0, 1));
            issue(rw, a, 4'($urandom), $urandom);
            if (a[1:0] == 2'b00 && $urandom_range(0, 5) == 0) collide($urandom & 32'hFFFF_FFFC);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        begin
            int g;
            g = 0;
            while (q.size() > 0 && g < 20) begin
                @(negedge clk);
                g++;
            end
            if (q.size() > 0) begin
                compared++;
                mismatched++;
                $display("FAIL drain: got %0d pending expected 0", q.size());
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
